// File: rtl/pipe_ctrl_pkg.sv
// ============================================================================
//  pipe_ctrl_pkg
//  Shared encodings for the pipeline hazard controller.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FENCE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_HALT  = 2'd3
    } ctrl_state_e;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_EXM = 2'b10;

    // addi x0,x0,0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic pc;
        logic if_id;
        logic id_ex;
        logic ex_mem;
        logic mem_wb;
    } stage_en_t;

    typedef struct packed {
        logic if_id;
        logic id_ex;
        logic ex_mem;
    } stage_flush_t;

    localparam stage_en_t    EN_ALL     = 5'b11111;
    localparam stage_en_t    EN_NONE    = 5'b00000;
    localparam stage_en_t    EN_HOLD_ID = 5'b00111;
    localparam stage_flush_t FL_NONE    = 3'b000;
    localparam stage_flush_t FL_BUBBLE  = 3'b010;
    localparam stage_flush_t FL_BRANCH  = 3'b111;

endpackage

`default_nettype wire

// File: rtl/pipe_fwd_sel.sv
// ============================================================================
//  pipe_fwd_sel
//  Operand forward select: youngest producer (EX/MEM) wins, x0 never forwarded.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module pipe_fwd_sel
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] ex_rs,
    input  logic [REG_AW-1:0] exm_rd,
    input  logic              exm_regwrite,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              wb_regwrite,
    output logic [1:0]        fwd
);

    logic w_exm_hit;
    logic w_wb_hit;

    always_comb begin
        w_exm_hit = exm_regwrite && (exm_rd != '0) && (exm_rd == ex_rs);
        w_wb_hit  = wb_regwrite  && (wb_rd  != '0) && (wb_rd  == ex_rs);
        fwd       = FWD_RF;
        if (w_exm_hit) begin
            fwd = FWD_EXM;
        end else if (w_wb_hit) begin
            fwd = FWD_WB;
        end
    end

endmodule

`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
// ============================================================================
//  pipe_hazard_ctrl
//  Stall/flush/forward/halt controller for the 5-stage RV32 pipeline.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_AW    = 5,
    parameter int LOAD_LAT  = 1,
    parameter int DRAIN_CYC = 3,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic              id_is_sys,
    input  logic              id_is_fence,
    input  logic [REG_AW-1:0] ex_rs1,
    input  logic [REG_AW-1:0] ex_rs2,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_memread,
    input  logic [REG_AW-1:0] exm_rd,
    input  logic              exm_regwrite,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              wb_regwrite,
    input  logic              br_taken,
    input  logic              dmem_ready,
    output logic              pc_en,
    output logic              if_id_en,
    output logic              id_ex_en,
    output logic              ex_mem_en,
    output logic              mem_wb_en,
    output logic              if_id_flush,
    output logic              id_ex_flush,
    output logic              ex_mem_flush,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              halted,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam int LU_W = $clog2(LOAD_LAT + 1);
    localparam int DR_W = $clog2(DRAIN_CYC + 1);

    ctrl_state_e      state_q,      state_d;
    logic [LU_W-1:0]  lu_tmr_q,     lu_tmr_d;
    logic [DR_W-1:0]  dr_tmr_q,     dr_tmr_d;
    logic             fence_done_q, fence_done_d;
    logic [CNT_W-1:0] stall_cnt_q,  stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q,  flush_cnt_d;

    stage_en_t        w_en;
    stage_flush_t     w_fl;
    logic             w_load_use;
    logic             w_stall_inc;
    logic             w_flush_inc;

    pipe_fwd_sel #(.REG_AW(REG_AW)) u_fwd_a (
        .ex_rs        (ex_rs1),
        .exm_rd       (exm_rd),
        .exm_regwrite (exm_regwrite),
        .wb_rd        (wb_rd),
        .wb_regwrite  (wb_regwrite),
        .fwd          (fwd_a)
    );

    pipe_fwd_sel #(.REG_AW(REG_AW)) u_fwd_b (
        .ex_rs        (ex_rs2),
        .exm_rd       (exm_rd),
        .exm_regwrite (exm_regwrite),
        .wb_rd        (wb_rd),
        .wb_regwrite  (wb_regwrite),
        .fwd          (fwd_b)
    );

    always_comb begin
        w_load_use = id_valid && ex_memread && (ex_rd != '0) &&
                     ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                      (id_use_rs2 && (id_rs2 == ex_rd)));
    end

    always_comb begin
        state_d      = state_q;
        lu_tmr_d     = lu_tmr_q;
        dr_tmr_d     = dr_tmr_q;
        fence_done_d = fence_done_q;
        w_en         = EN_ALL;
        w_fl         = FL_NONE;
        w_stall_inc  = 1'b0;
        w_flush_inc  = 1'b0;

        if (state_q == ST_HALT) begin
            w_en = EN_NONE;
        end else if (!dmem_ready) begin
            w_en        = EN_NONE;
            w_stall_inc = 1'b1;
        end else if (br_taken) begin
            // An older taken branch squashes whatever sits in ID, including
            // a fence or ecall that is still being held there.
            w_fl         = FL_BRANCH;
            w_flush_inc  = 1'b1;
            lu_tmr_d     = '0;
            dr_tmr_d     = '0;
            fence_done_d = 1'b0;
            state_d      = ST_RUN;
        end else if ((state_q == ST_FENCE) || (state_q == ST_DRAIN)) begin
            w_en = EN_HOLD_ID;
            w_fl = FL_BUBBLE;
            if (dr_tmr_q <= DR_W'(1)) begin
                dr_tmr_d = '0;
                if (state_q == ST_FENCE) begin
                    state_d      = ST_RUN;
                    fence_done_d = 1'b1;
                end else begin
                    state_d = ST_HALT;
                end
            end else begin
                dr_tmr_d = dr_tmr_q - DR_W'(1);
            end
        end else if (id_valid && (id_is_sys || (id_is_fence && !fence_done_q))) begin
            // Entry cycle is the first of the DRAIN_CYC hold cycles.
            w_en     = EN_HOLD_ID;
            w_fl     = FL_BUBBLE;
            lu_tmr_d = '0;
            if (DRAIN_CYC > 1) begin
                state_d  = id_is_sys ? ST_DRAIN : ST_FENCE;
                dr_tmr_d = DR_W'(DRAIN_CYC - 1);
            end else if (id_is_sys) begin
                state_d = ST_HALT;
            end else begin
                fence_done_d = 1'b1;
            end
        end else if (lu_tmr_q != '0) begin
            w_en        = EN_HOLD_ID;
            w_fl        = FL_BUBBLE;
            w_stall_inc = 1'b1;
            lu_tmr_d    = lu_tmr_q - LU_W'(1);
        end else if (w_load_use) begin
            w_en        = EN_HOLD_ID;
            w_fl        = FL_BUBBLE;
            w_stall_inc = 1'b1;
            lu_tmr_d    = LU_W'(LOAD_LAT - 1);
        end else begin
            fence_done_d = 1'b0;
        end

        stall_cnt_d = stall_cnt_q;
        if (w_stall_inc && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        flush_cnt_d = flush_cnt_q;
        if (w_flush_inc && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_RUN;
            lu_tmr_q     <= '0;
            dr_tmr_q     <= '0;
            fence_done_q <= 1'b0;
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            lu_tmr_q     <= lu_tmr_d;
            dr_tmr_q     <= dr_tmr_d;
            fence_done_q <= fence_done_d;
            stall_cnt_q  <= stall_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    always_comb begin
        pc_en        = w_en.pc;
        if_id_en     = w_en.if_id;
        id_ex_en     = w_en.id_ex;
        ex_mem_en    = w_en.ex_mem;
        mem_wb_en    = w_en.mem_wb;
        if_id_flush  = w_fl.if_id;
        id_ex_flush  = w_fl.id_ex;
        ex_mem_flush = w_fl.ex_mem;
        halted       = (state_q == ST_HALT);
        stall_cnt    = stall_cnt_q;
        flush_cnt    = flush_cnt_q;
    end

endmodule

`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
// ============================================================================
//  tb_pipe_hazard_ctrl
//  Scoreboard bench for the pipeline hazard controller.
//  Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_pipe_hazard_ctrl;

    localparam int REG_AW    = 5;
    localparam int LOAD_LAT  = 2;
    localparam int DRAIN_CYC = 3;
    localparam int CNT_W     = 8;
    localparam int CNT_MAX   = (1 << CNT_W) - 1;

    localparam logic [4:0] EN_ALL  = 5'b11111;
    localparam logic [4:0] EN_HOLD = 5'b00111;
    localparam logic [4:0] EN_NONE = 5'b00000;
    localparam logic [2:0] FL_NONE = 3'b000;
    localparam logic [2:0] FL_BUB  = 3'b010;
    localparam logic [2:0] FL_BR   = 3'b111;

    logic              clk = 1'b0;
    logic              rst;
    logic              id_valid, id_use_rs1, id_use_rs2, id_is_sys, id_is_fence;
    logic [REG_AW-1:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, exm_rd, wb_rd;
    logic              ex_memread, exm_regwrite, wb_regwrite, br_taken, dmem_ready;
    logic              pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic              if_id_flush, id_ex_flush, ex_mem_flush, halted;
    logic [1:0]        fwd_a, fwd_b;
    logic [CNT_W-1:0]  stall_cnt, flush_cnt;

    typedef struct {
        string            tag;
        logic [4:0]       en;
        logic [2:0]       fl;
        logic [1:0]       fa;
        logic [1:0]       fb;
        logic             h;
        logic [CNT_W-1:0] sc;
        logic [CNT_W-1:0] fc;
    } exp_t;

    exp_t sbq[$];
    exp_t cur;
    int   n_checks  = 0;
    int   n_errors  = 0;
    int   exp_stall = 0;
    int   exp_flush = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(
        .REG_AW(REG_AW), .LOAD_LAT(LOAD_LAT), .DRAIN_CYC(DRAIN_CYC), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_is_sys(id_is_sys), .id_is_fence(id_is_fence),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_memread(ex_memread),
        .exm_rd(exm_rd), .exm_regwrite(exm_regwrite),
        .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
        .br_taken(br_taken), .dmem_ready(dmem_ready),
        .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
        .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .halted(halted),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (sbq.size() > 0) begin
            cur = sbq.pop_front();
            check_val({cur.tag, ".en"},
                      32'({pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en}), 32'(cur.en));
            check_val({cur.tag, ".flush"},
                      32'({if_id_flush, id_ex_flush, ex_mem_flush}), 32'(cur.fl));
            check_val({cur.tag, ".fwd_a"},  32'(fwd_a),     32'(cur.fa));
            check_val({cur.tag, ".fwd_b"},  32'(fwd_b),     32'(cur.fb));
            check_val({cur.tag, ".halted"}, 32'(halted),    32'(cur.h));
            check_val({cur.tag, ".stall"},  32'(stall_cnt), 32'(cur.sc));
            check_val({cur.tag, ".flushc"}, 32'(flush_cnt), 32'(cur.fc));
        end
    end

    task automatic idle();
        id_valid = 0; id_use_rs1 = 0; id_use_rs2 = 0; id_is_sys = 0; id_is_fence = 0;
        id_rs1 = '0; id_rs2 = '0; ex_rs1 = '0; ex_rs2 = '0; ex_rd = '0; ex_memread = 0;
        exm_rd = '0; exm_regwrite = 0; wb_rd = '0; wb_regwrite = 0;
        br_taken = 0; dmem_ready = 1;
    endtask

    task automatic skip();
        @(posedge clk);
        #1;
    endtask

    // Push the expectation for the cycle just driven; counters show the
    // count before this cycle, then advance the model by what it should add.
    task automatic cyc(input string tag, input logic [4:0] en, input logic [2:0] fl,
                       input logic [1:0] fa, input logic [1:0] fb, input logic h,
                       input bit inc_s, input bit inc_f);
        exp_t e;
        e.tag = tag; e.en = en; e.fl = fl; e.fa = fa; e.fb = fb; e.h = h;
        e.sc  = CNT_W'(exp_stall);
        e.fc  = CNT_W'(exp_flush);
        sbq.push_back(e);
        @(posedge clk);
        #1;
        if (inc_s && exp_stall < CNT_MAX) exp_stall++;
        if (inc_f && exp_flush < CNT_MAX) exp_flush++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        rst = 1'b0;
        skip();
        cyc("reset", EN_ALL, FL_NONE, 2'b00, 2'b00, 0, 0, 0);
        rst = 1'b1;

        exm_rd = 7; exm_regwrite = 1; wb_rd = 7; wb_regwrite = 1; ex_rs1 = 7; ex_rs2 = 0;
        cyc("fwd_exm", EN_ALL, FL_NONE, 2'b10, 2'b00, 0, 0, 0);
        exm_rd = 0;
        cyc("fwd_wb", EN_ALL, FL_NONE, 2'b01, 2'b00, 0, 0, 0);
        exm_rd = 7; ex_rs2 = 7; exm_regwrite = 0;
        cyc("fwd_wb_only", EN_ALL, FL_NONE, 2'b01, 2'b01, 0, 0, 0);
        exm_regwrite = 1; wb_rd = 3; ex_rs1 = 3;
        cyc("fwd_mix", EN_ALL, FL_NONE, 2'b01, 2'b10, 0, 0, 0);
        exm_rd = 0; wb_rd = 0; ex_rs1 = 0; ex_rs2 = 0;
        cyc("fwd_x0", EN_ALL, FL_NONE, 2'b00, 2'b00, 0, 0, 0);
        idle();

        // lw x5 in EX, add x6,x5,x1 in ID
        id_valid = 1; id_rs1 = 5; id_rs2 = 1; id_use_rs1 = 1; id_use_rs2 = 1;
        ex_memread = 1; ex_rd = 5;
        cyc("lu1", EN_HOLD, FL_BUB, 2'b00, 2'b00, 0, 1, 0);
        ex_memread = 0; ex_rd = 0;
        cyc("lu2", EN_HOLD, FL_BUB, 2'b00, 2'b00, 0, 1, 0);
        cyc("lu_done", EN_ALL, FL_NONE, 2'b00, 2'b00, 0, 0, 0);
        id_use_rs1 = 0; ex_memread = 1; ex_rd = 5;
        cyc("lu_unused", EN_ALL, FL_NONE, 2'b00, 2'b00, 0, 0, 0);
        id_use_rs1 = 1; id_rs1 = 0; ex_rd = 0;
        cyc("lu_x0", EN_ALL, FL_NONE, 2'b00, 2'b00, 0, 0, 0);
        idle();

        id_valid = 1; id_is_sys = 1; id_use_rs1 = 1; id_rs1 = 5;
        ex_memread = 1; ex_rd = 5; br_taken = 1;
        cyc("br", EN_ALL, FL_BR, 2'b00, 2'b00, 0, 0, 1);
        idle();
        cyc("br_after1", EN_ALL, FL_NONE, 2'b00, 2'b00, 0, 0, 0);
        cyc("br_after2", EN_ALL, FL_NONE, 2'b00, 2'b00, 0, 0, 0);

        id_valid = 1; id_rs1 = 2; id_rs2 = 5; id_use_rs1 = 1; id_use_rs2 = 1;
        ex_memread = 1; ex_rd = 5;
        cyc("fz_lu", EN_HOLD, FL_BUB, 2'b00, 2'b00, 0, 1, 0);
        ex_memread = 0; ex_rd = 0; dmem_ready = 0;
        for (int i = 0; i < 4; i++) begin
            cyc("fz_hold", EN_NONE, FL_NONE, 2'b00, 2'b00, 0, 1, 0);
        end
        dmem_ready = 1;
        cyc("fz_resume", EN_HOLD, FL_BUB, 2'b00, 2'b00, 0, 1, 0);
        cyc("fz_done", EN_ALL, FL_NONE, 2'b00, 2'b00, 0, 0, 0);
        idle();
        br_taken = 1; dmem_ready = 0;
        cyc("fz_br", EN_NONE, FL_NONE, 2'b00, 2'b00, 0, 1, 0);
        idle();

        id_valid = 1; id_is_fence = 1;
        for (int i = 0; i < DRAIN_CYC; i++) begin
            cyc("fence_hold", EN_HOLD, FL_BUB, 2'b00, 2'b00, 0, 0, 0);
        end
        cyc("fence_rel", EN_ALL, FL_NONE, 2'b00, 2'b00, 0, 0, 0);
        idle();
        cyc("fence_after", EN_ALL, FL_NONE, 2'b00, 2'b00, 0, 0, 0);

        id_valid = 1; id_is_sys = 1;
        for (int i = 0; i < DRAIN_CYC; i++) begin
            cyc("sys_drain", EN_HOLD, FL_BUB, 2'b00, 2'b00, 0, 0, 0);
        end
        cyc("halt1", EN_NONE, FL_NONE, 2'b00, 2'b00, 1, 0, 0);
        br_taken = 1;
        cyc("halt_br", EN_NONE, FL_NONE, 2'b00, 2'b00, 1, 0, 0);
        br_taken = 0; dmem_ready = 0;
        cyc("halt_fz", EN_NONE, FL_NONE, 2'b00, 2'b00, 1, 0, 0);
        dmem_ready = 1; exm_rd = 4; exm_regwrite = 1; ex_rs1 = 4;
        cyc("halt_fwd", EN_NONE, FL_NONE, 2'b10, 2'b00, 1, 0, 0);
        rst = 1'b0;
        idle();
        skip();
        rst = 1'b1;
        exp_stall = 0; exp_flush = 0;
        cyc("post_rst", EN_ALL, FL_NONE, 2'b00, 2'b00, 0, 0, 0);

        id_valid = 1; id_is_sys = 1;
        cyc("d1", EN_HOLD, FL_BUB, 2'b00, 2'b00, 0, 0, 0);
        cyc("d2", EN_HOLD, FL_BUB, 2'b00, 2'b00, 0, 0, 0);
        rst = 1'b0;
        idle();
        skip();
        rst = 1'b1;
        for (int i = 0; i < DRAIN_CYC + 1; i++) begin
            cyc("drain_rst", EN_ALL, FL_NONE, 2'b00, 2'b00, 0, 0, 0);
        end

        dmem_ready = 0;
        for (int i = 0; i < CNT_MAX + 5; i++) begin
            cyc("sat", EN_NONE, FL_NONE, 2'b00, 2'b00, 0, 1, 0);
        end
        dmem_ready = 1;
        cyc("sat_hold", EN_ALL, FL_NONE, 2'b00, 2'b00, 0, 0, 0);

        for (int i = 0; i < 4 && sbq.size() > 0; i++) begin
            @(negedge clk);
        end
        check_val("sb_empty", 32'(sbq.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
